// File: rtl/acc_core_mc.sv
// rtl/acc_core_mc.sv - multi-cycle accumulator core, 9-bit instructions, req/ack data memory
// Optional retired-instruction counter: define ACC_CORE_PERF_CNT_EN to add the perf_instr port.
module acc_core_mc #(
    parameter int DW   = 8,
    parameter int PW   = 12,
    parameter int NREG = 16,
    parameter int LUTW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [PW-1:0]   imem_addr,
    input  logic [8:0]      imem_data,
    output logic [LUTW-1:0] lut_idx,
    input  logic [PW-1:0]   lut_target,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic [DW-1:0]   dmem_rdata,
    input  logic            dmem_ack,
    output logic [PW-1:0]   pc,
    output logic            done
`ifdef ACC_CORE_PERF_CNT_EN
    ,
    output logic [31:0]     perf_instr
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND = 4'h3, OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_LI  = 4'h7, OP_MOVF = 4'h8;
    localparam logic [3:0] OP_MOVT = 4'h9, OP_LD   = 4'hA, OP_ST  = 4'hB, OP_CMP  = 4'hC;
    localparam logic [3:0] OP_BRF  = 4'hD, OP_JMP  = 4'hE, OP_HALT = 4'hF;

    state_t          state;
    logic [8:0]      instr;
    logic [DW-1:0]   regs [NREG];
    logic            flag;

    logic [3:0]      op;
    logic [3:0]      rn_idx;
    logic            rn_ok;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   r0;
    logic [DW-1:0]   rn_val;
    logic [DW:0]     sum;
    logic [DW:0]     diff;
    logic [PW-1:0]   pc_inc;

    assign op     = instr[8:5];
    assign rn_idx = instr[4:1];
    assign rn_ok  = int'(rn_idx) < NREG;
    assign imm    = DW'(instr[4:0]);
    assign r0     = regs[0];
    assign sum    = {1'b0, r0} + {1'b0, rn_val};
    assign diff   = {1'b0, r0} - {1'b0, rn_val};
    assign pc_inc = pc + PW'(1);

    always_comb begin
        rn_val = '0;
        if (rn_ok)
            rn_val = regs[rn_idx];
    end

    assign imem_addr  = pc;
    assign lut_idx    = instr[LUTW-1:0];
    assign dmem_addr  = rn_val;
    assign dmem_wdata = r0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= '0;
            instr    <= '0;
            flag     <= 1'b0;
            done     <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pc    <= '0;
                    state <= FETCH;
                end
                FETCH: begin
                    instr <= imem_data;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    pc    <= pc_inc;
                    case (op)
                        OP_ADD:  begin regs[0] <= sum[DW-1:0];  flag <= sum[DW];  end
                        OP_SUB:  begin regs[0] <= diff[DW-1:0]; flag <= diff[DW]; end
                        OP_AND:  regs[0] <= r0 & rn_val;
                        OP_OR:   regs[0] <= r0 | rn_val;
                        OP_XOR:  regs[0] <= r0 ^ rn_val;
                        OP_SHL:  begin regs[0] <= {r0[DW-2:0], 1'b0}; flag <= r0[DW-1]; end
                        OP_LI:   regs[0] <= imm;
                        OP_MOVF: if (rn_ok) regs[rn_idx] <= r0;
                        OP_MOVT: regs[0] <= rn_val;
                        OP_LD, OP_ST: begin
                            // pc advances only once the memory acknowledges
                            pc       <= pc;
                            state    <= MEM;
                            dmem_req <= 1'b1;
                            dmem_we  <= (op == OP_ST);
                        end
                        OP_CMP:  flag <= (r0 == rn_val);
                        OP_BRF:  pc <= flag ? lut_target : pc_inc;
                        OP_JMP:  pc <= lut_target;
                        OP_HALT: begin
                            pc    <= pc;
                            state <= HALT;
                            done  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEM: if (dmem_ack) begin
                    if (!dmem_we)
                        regs[0] <= dmem_rdata;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    pc       <= pc_inc;
                    state    <= FETCH;
                end
                HALT: if (start) begin
                    pc    <= '0;
                    done  <= 1'b0;
                    state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACC_CORE_PERF_CNT_EN
    logic retire;
    logic restart;

    assign retire  = (state == EXEC && op != OP_LD && op != OP_ST) || (state == MEM && dmem_ack);
    assign restart = start && (state == IDLE || state == HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            perf_instr <= '0;
        else if (restart)
            perf_instr <= '0;
        else if (retire && perf_instr != '1)
            perf_instr <= perf_instr + 32'd1;
    end
`endif

endmodule

// File: tb/tb_acc_core_mc.sv
// tb/tb_acc_core_mc.sv - directed vector bench for acc_core_mc
module tb_acc_core_mc;
    localparam int DW = 8, PW = 12, NREG = 16, LUTW = 5;

    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, AND = 4'h3, OR = 4'h4, XOR = 4'h5;
    localparam logic [3:0] SHL = 4'h6, LI = 4'h7, MOVF = 4'h8, MOVT = 4'h9, LD = 4'hA, ST = 4'hB;
    localparam logic [3:0] CMP = 4'hC, BRF = 4'hD, JMP = 4'hE;
    localparam logic [8:0] H = 9'h1E0;

    logic            clk = 1'b0;
    logic            reset_n, start;
    logic [PW-1:0]   imem_addr, lut_target, pc;
    logic [8:0]      imem_data;
    logic [LUTW-1:0] lut_idx;
    logic            dmem_req, dmem_we, dmem_ack, done;
    logic [DW-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
`ifdef ACC_CORE_PERF_CNT_EN
    logic [31:0]     perf_instr;
`endif

    logic [8:0]      rom [4096];
    logic [PW-1:0]   lut [32];

    assign imem_data  = rom[imem_addr];
    assign lut_target = lut[lut_idx];

    always #5 clk = ~clk;

    acc_core_mc #(.DW(DW), .PW(PW), .NREG(NREG), .LUTW(LUTW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .lut_idx(lut_idx), .lut_target(lut_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .done(done)
`ifdef ACC_CORE_PERF_CNT_EN
        , .perf_instr(perf_instr)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0][8:0] prog;
        int               cycles;
        logic [7:0]       r0;
        logic [11:0]      pc;
        logic             flag;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ins(input logic [3:0] op, input logic [4:0] f);
        return {op, f};
    endfunction

    function automatic logic [8:0] rr(input logic [3:0] op, input logic [3:0] n);
        return {op, n, 1'b0};
    endfunction

    function automatic vec_t mk(input logic [8:0] a, b, c, d, e, f, g,
                                input int cyc, input logic [7:0] r0,
                                input logic [11:0] p, input logic fl);
        vec_t v;
        v.prog = {12{H}};
        v.prog[0] = a; v.prog[1] = b; v.prog[2] = c; v.prog[3] = d;
        v.prog[4] = e; v.prog[5] = f; v.prog[6] = g;
        v.cycles = cyc; v.r0 = r0; v.pc = p; v.flag = fl;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic mem_xfer(input string tag, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata, input int delay, input logic [7:0] rdata);
        int n = 0;
        while (!dmem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, we);
        chk({tag, "_addr"}, dmem_addr, addr);
        if (we)
            chk({tag, "_wdata"}, dmem_wdata, wdata);
        n = 0;
        while (dmem_req && n < 20) begin
            n++;
            if (n == delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            dmem_ack   = 1'b0;
            dmem_rdata = '0;
        end
        chk({tag, "_req_cycles"}, n, delay);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        for (int i = 0; i < 4096; i++) rom[i] = H;
        for (int i = 0; i < 32; i++) lut[i] = '0;
        lut[3] = 12'd20; lut[5] = 12'd30; lut[7] = 12'd4094;

        vecs[0] = mk(ins(LI, 7), rr(MOVF, 1), ins(LI, 30), rr(ADD, 1), H, H, H, 10, 8'd37, 12'd4, 1'b0);
        vecs[1] = mk(ins(LI, 31), rr(SHL, 0), rr(SHL, 0), rr(SHL, 0), rr(SHL, 0), H, H, 12, 8'hF0, 12'd5, 1'b1);
        vecs[2] = mk(ins(LI, 5), rr(MOVF, 2), ins(LI, 3), rr(SUB, 2), H, H, H, 10, 8'hFE, 12'd4, 1'b1);
        vecs[3] = mk(ins(LI, 12), rr(MOVF, 3), ins(LI, 10), rr(XOR, 3), rr(OR, 3), rr(AND, 3), H, 14, 8'd12, 12'd6, 1'b1);
        vecs[4] = mk(ins(LI, 9), rr(MOVF, 4), ins(LI, 0), rr(CMP, 4), rr(MOVT, 4), H, H, 12, 8'd9, 12'd5, 1'b0);
        vecs[5] = mk(ins(LI, 1), rr(MOVF, 1), ins(LI, 0), rr(SUB, 1), rr(ADD, 1), ins(BRF, 3), H, 14, 8'h00, 12'd20, 1'b1);
        vecs[6] = mk(ins(LI, 1), rr(SUB, 1), ins(BRF, 3), H, H, H, H, 8, 8'h00, 12'd3, 1'b0);
        vecs[7] = mk(ins(LI, 4), ins(JMP, 5), H, H, H, H, H, 6, 8'd4, 12'd30, 1'b0);
        vecs[8] = mk(ins(LI, 17), rr(MOVF, 0), rr(ADD, 0), H, H, H, H, 8, 8'd34, 12'd3, 1'b0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_done", done, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_r0", dmem_wdata, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_pc", pc, 0);

        for (int v = 0; v < 9; v++) begin
            for (int j = 0; j < 12; j++) rom[j] = vecs[v].prog[j];
            pulse_start();
            chk($sformatf("v%0d_done_fall", v), done, 0);
`ifdef ACC_CORE_PERF_CNT_EN
            chk($sformatf("v%0d_perf_clr", v), perf_instr, 0);
`endif
            wait_done($sformatf("v%0d", v), n);
            chk($sformatf("v%0d_cycles", v), n, vecs[v].cycles);
            chk($sformatf("v%0d_r0", v), dmem_wdata, vecs[v].r0);
            chk($sformatf("v%0d_pc", v), pc, vecs[v].pc);
            chk($sformatf("v%0d_flag", v), dut.flag, vecs[v].flag);
`ifdef ACC_CORE_PERF_CNT_EN
            chk($sformatf("v%0d_perf", v), perf_instr, vecs[v].cycles / 2);
`endif
        end

        // memory stall: LD waits 4 cycles for ack, then ST of the loaded value
        rom[0] = ins(LI, 9); rom[1] = rr(MOVF, 6); rom[2] = rr(LD, 6); rom[3] = rr(ST, 6); rom[4] = H;
        pulse_start();
        mem_xfer("ld", 1'b0, 8'd9, 8'd0, 4, 8'hA5);
        chk("ld_pc", pc, 3);
        chk("ld_r0", dmem_wdata, 8'hA5);
        mem_xfer("st", 1'b1, 8'd9, 8'hA5, 1, 8'h00);
        chk("st_pc", pc, 4);
        wait_done("mem", n);
        chk("mem_halt_pc", pc, 4);
        chk("mem_r0", dmem_wdata, 8'hA5);
`ifdef ACC_CORE_PERF_CNT_EN
        chk("mem_perf", perf_instr, 5);
`endif

        // pc wrap through 4095, with a start pulse landing in EXEC
        rom[0] = ins(JMP, 7); rom[4094] = ins(NOP, 0); rom[4095] = ins(NOP, 0);
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_exec_pc", pc, 4094);
        n = 0;
        while (pc != 12'd4095 && n < 20) begin @(negedge clk); n++; end
        chk("reach_4095", pc, 4095);
        rom[0] = H;
        n = 0;
        while (pc == 12'd4095 && n < 20) begin @(negedge clk); n++; end
        chk("pc_wrap", pc, 0);
        wait_done("wrap", n);
        chk("wrap_halt_pc", pc, 0);
`ifdef ACC_CORE_PERF_CNT_EN
        chk("wrap_perf", perf_instr, 4);
`endif

        // reset while a load is waiting for ack
        rom[0] = rr(LD, 6);
        pulse_start();
        n = 0;
        while (!dmem_req && n < 20) begin @(negedge clk); n++; end
        chk("rmem_req", dmem_req, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rmem_req_drop", dmem_req, 0);
        chk("rmem_pc", pc, 0);
        chk("rmem_r0", dmem_wdata, 0);
        chk("rmem_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rmem_idle_req", dmem_req, 0);
        chk("rmem_idle_pc", pc, 0);
        chk("rmem_idle_done", done, 0);
`ifdef ACC_CORE_PERF_CNT_EN
        chk("rmem_perf", perf_instr, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
